// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Adds two W-bit operands (W = 4*NIBBLES) over NIBBLES clock cycles. A
//   single 4-bit ripple-carry stage is reused for every pass, least
//   significant nibble first. The result is held until the consumer takes it.
//
//   Optional feature: define NIBBLE_ADD_SUB_EN to add the in_sub port. When
//   in_sub is high at accept, the result is in_a - in_b. B is inverted into the
//   stage, the initial carry is forced to 1 and in_cin is ignored. out_cout = 1
//   then means no borrow occurred.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand request valid
//   in_ready   high in IDLE: an operand set can be accepted
//   in_a/in_b  W-bit operands, sampled on accept
//   in_cin     carry-in, sampled on accept
//   in_sub     (NIBBLE_ADD_SUB_EN only) subtract select, sampled on accept
//   out_valid  high in DONE: result valid
//   out_ready  consumer takes the result
//   out_sum    registered W-bit sum
//   out_cout   registered carry-out of the most-significant nibble
//   busy       high in RUN or DONE
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic                   in_sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      b_eff;
    logic [3:0]      stage_sum;
    logic [4:0]      rc;
    logic            stage_cout;
    logic [W-1:0]    sum_next;
    logic            last_pass;

`ifdef NIBBLE_ADD_SUB_EN
    logic            sub_r;
`endif

    assign last_pass = (cnt == CW'(NIBBLES - 1));

    // Select the current nibble of each operand with constant part-selects.
    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                a_nib = op_a[4*i +: 4];
                b_nib = op_b[4*i +: 4];
            end
        end
    end

`ifdef NIBBLE_ADD_SUB_EN
    assign b_eff = sub_r ? ~b_nib : b_nib;
`else
    assign b_eff = b_nib;
`endif

    // The one shared 4-bit ripple-carry stage.
    always_comb begin
        rc[0] = carry;
        for (int i = 0; i < 4; i++) begin
            stage_sum[i] = a_nib[i] ^ b_eff[i] ^ rc[i];
            rc[i+1]      = (a_nib[i] & b_eff[i]) | (rc[i] & (a_nib[i] ^ b_eff[i]));
        end
        stage_cout = rc[4];
    end

    // Merge the fresh nibble into the running sum at position cnt.
    always_comb begin
        sum_next = out_sum;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                sum_next[4*i +: 4] = stage_sum;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_pass) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // NOTE: every datapath register is reset, including the operand copies.
    // An aborted operation then leaves nothing behind that could become visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            carry    <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
            sub_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= in_a;
                        op_b  <= in_b;
                        cnt   <= '0;
`ifdef NIBBLE_ADD_SUB_EN
                        sub_r <= in_sub;
                        carry <= in_sub ? 1'b1 : in_cin;
`else
                        carry <= in_cin;
`endif
                    end
                end
                RUN: begin
                    out_sum <= sum_next;
                    carry   <= stage_cout;
                    cnt     <= cnt + CW'(1);
                    if (last_pass) begin
                        out_cout <= stage_cout;
                    end
                end
                default: ;  // DONE: result held until taken
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit passes; operand width W = 4*NIBBLES; legal range 1..8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  controller can accept an operand set.
REQ-006 SHALL have ports in_a, in_b  input  W each  operands, sampled only on accept.
REQ-007 SHALL have port in_cin  input  1  carry-in, sampled only on accept.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_sum  output  W  registered sum.
REQ-011 SHALL have port out_cout  output  1  registered carry-out of the most-significant nibble.
REQ-012 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL use exactly one 4-bit ripple-carry add stage (4-bit A, 4-bit B, carry-in; 4-bit sum, carry-out), time-shared over all nibbles.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL accept when in_valid && in_ready: latch in_a, in_b into operand registers, in_cin into the carry register, clear nibble counter to 0, enter RUN.
REQ-016 SHALL, each RUN cycle, add nibble[cnt] of A and B with the carry register, write the 4-bit result into sum bits [4*cnt+3:4*cnt], load the stage carry-out into the carry register, increment cnt.
REQ-017 SHALL process nibbles LSB first and leave RUN for DONE on the cycle cnt==NIBBLES-1 completes.
REQ-018 SHALL assert out_valid exactly NIBBLES clock edges after the accepting edge (NIBBLES=4: accept edge 0, out_valid high after edge 4).
REQ-019 SHALL, in DONE, present out_cout = final carry register; hold out_sum and out_cout stable while out_valid && !out_ready.
REQ-020 SHALL, on out_valid && out_ready, return to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
REQ-021 SHALL ignore in_valid, in_a, in_b, in_cin in RUN and DONE.
REQ-022 SHALL keep out_sum/out_cout at their last completed result in IDLE; out_sum is not updated partially while out_valid is high.
REQ-023 SHALL compute out_sum/out_cout equal to the W-bit sum in_a + in_b + in_cin, with out_cout the bit-W carry; no saturation.

Reset
REQ-024 SHALL on rst_n low, immediately and regardless of state: state=IDLE, cnt=0, carry=0, operand registers=0, out_sum=0, out_cout=0, in_ready=1, out_valid=0, busy=0.
REQ-025 SHALL discard any in-flight operation on reset mid-RUN or mid-DONE; no result is emitted after release.
REQ-026 SHALL accept a new request on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when macro NIBBLE_ADD_SUB_EN is defined, add port in_sub  input  1 (sampled on accept); when in_sub=1 result = in_a - in_b (B nibbles inverted into the stage, initial carry forced to 1, in_cin ignored), out_cout = 1 means no borrow.
REQ-028 SHALL, when NIBBLE_ADD_SUB_EN is undefined, omit in_sub and perform addition only, with identical timing.

Verification
REQ-029 SHALL verify: NIBBLES=4, in_a=0x1234, in_b=0x4321, in_cin=0 -> out_sum=0x5555, out_cout=0, out_valid high exactly 4 edges after accept.
REQ-030 SHALL verify: in_a=0xFFFF, in_b=0x0001, in_cin=0 -> out_sum=0x0000, out_cout=1 (carry ripples through all 4 passes); in_a=0xFFFF, in_b=0x0000, in_cin=1 -> same result.
REQ-031 SHALL verify: out_ready low 3 cycles in DONE -> out_valid, out_sum, out_cout held constant; in_ready stays 0; in_valid pulses during RUN/DONE are not accepted.
REQ-032 SHALL verify: rst_n pulsed low after 2 RUN cycles -> outputs reach reset values asynchronously; no out_valid follows; next request 0x0001+0x0001 -> 0x0002.
REQ-033 SHALL verify (NIBBLE_ADD_SUB_EN): in_a=0x0005, in_b=0x0007, in_sub=1 -> out_sum=0xFFFE, out_cout=0; in_a=0x0007, in_b=0x0005 -> 0x0002, out_cout=1.
REQ-034 SHALL verify: back-to-back requests with in_valid held high and out_ready=1 -> one accept per NIBBLES+2 cycles, results in order.
